// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scroller: character codes,
// active-low segment patterns (gfedcba) and the scroll state encoding.
package seg_pkg;

    localparam logic [4:0] CH_BLANK = 5'h10;
    localparam logic [4:0] CH_H     = 5'h11;
    localparam logic [4:0] CH_L     = 5'h12;
    localparam logic [4:0] CH_P     = 5'h13;
    localparam logic [4:0] CH_U     = 5'h14;
    localparam logic [4:0] CH_DASH  = 5'h15;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/seg_char_decode.sv
// Combinational 5-bit character code to active-low 7-segment pattern
// (gfedcba). Unassigned codes display blank.
module seg_char_decode
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default assigned before the case so every path drives seg and no latch is inferred.
        seg = SEG_BLANK;
        case (code)
            5'h00:    seg = 7'b1000000;
            5'h01:    seg = 7'b1111001;
            5'h02:    seg = 7'b0100100;
            5'h03:    seg = 7'b0110000;
            5'h04:    seg = 7'b0011001;
            5'h05:    seg = 7'b0010010;
            5'h06:    seg = 7'b0000010;
            5'h07:    seg = 7'b1111000;
            5'h08:    seg = 7'b0000000;
            5'h09:    seg = 7'b0010000;
            5'h0A:    seg = 7'b0001000;
            5'h0B:    seg = 7'b0000011;
            5'h0C:    seg = 7'b1000110;
            5'h0D:    seg = 7'b0100001;
            5'h0E:    seg = 7'b0000110;
            5'h0F:    seg = 7'b0001110;
            CH_BLANK: seg = SEG_BLANK;
            CH_H:     seg = SEG_H;
            CH_L:     seg = SEG_L;
            CH_P:     seg = SEG_P;
            CH_U:     seg = SEG_U;
            CH_DASH:  seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scroll_engine.sv
// Message scroller: loadable character buffer viewed through a 4-digit window
// that advances once per prescaler period; HEX outputs are registered.
module seg_scroll_engine
    import seg_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int STEP_HZ = 1,
    parameter int MAX_LEN = 16,
    localparam int AW     = $clog2(MAX_LEN)
)(
    input  logic          CLOCK_50,
    input  logic          RESET,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [4:0]    wr_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          pause,
    output logic          busy,
    output logic          step,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX0
);

    localparam int            TC_INT  = CLK_HZ / STEP_HZ - 1;
    localparam int            CW      = $clog2(TC_INT + 1);
    localparam logic [CW-1:0] TC      = CW'(TC_INT);
    localparam logic [AW:0]   LEN_MAX = (AW + 1)'(MAX_LEN);

    state_t        state, state_nx;
    logic [AW-1:0] ptr;
    logic [AW:0]   len_q;
    logic [AW:0]   ptr_inc;
    logic [CW-1:0] count;
    logic [4:0]    mem [MAX_LEN];
    logic [4:0]    ch  [4];
    logic [6:0]    seg [4];
    logic          start_ok;
    logic          tick;

    // (p + k) mod len for k <= 3; len may be smaller than 4, so up to three wraps.
    function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] p, input logic [1:0] k,
                                              input logic [AW:0] len);
        logic [AW+1:0] s;
        s = {2'b00, p} + {{AW{1'b0}}, k};
        for (int n = 0; n < 3; n++) begin
            if (s >= {1'b0, len}) s = s - {1'b0, len};
        end
        return AW'(s);
    endfunction

    assign start_ok = start && (msg_len != '0);
    assign tick     = (state == RUN) && (count == TC);
    assign ptr_inc  = {1'b0, ptr} + (AW + 1)'(1);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (start_ok) state_nx = RUN;
            RUN, PAUSE: state_nx = pause ? PAUSE : RUN;
            default:    state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            ptr   <= '0;
            len_q <= '0;
            count <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_nx;
            step  <= 1'b0;
            if (start_ok) begin
                ptr   <= '0;
                count <= '0;
                len_q <= (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
            end else if (tick) begin
                count <= '0;
                step  <= 1'b1;
                ptr   <= (ptr_inc == len_q) ? '0 : ptr_inc[AW-1:0];
            end else if (state == RUN) begin
                count <= count + CW'(1);
            end
        end
    end

    // NOTE: the buffer must power up blank, so it is reset entry by entry and maps to flops, not RAM.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < MAX_LEN; i++) mem[i] <= CH_BLANK;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) ch[k] = mem[win_idx(ptr, 2'(k), len_q)];
    end

    for (genvar k = 0; k < 4; k++) begin : g_dec
        seg_char_decode u_dec (
            .code (ch[k]),
            .seg  (seg[k])
        );
    end

    // Display reads pre-write buffer contents; a same-cycle write shows one cycle later.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            HEX3 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX0 <= SEG_BLANK;
        end else if (state == IDLE) begin
            HEX3 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX0 <= SEG_BLANK;
        end else begin
            HEX3 <= seg[0];
            HEX2 <= seg[1];
            HEX1 <= seg[2];
            HEX0 <= seg[3];
        end
    end

endmodule

// File: tb/tb_seg_scroll_engine.sv
// Self-checking bench for seg_scroll_engine: a per-cycle behavioural model plus
// directed scenarios with literal glyph expectations and a randomized phase.
module tb_seg_scroll_engine;

    localparam int CLK_HZ  = 8;
    localparam int STEP_HZ = 1;
    localparam int MAX_LEN = 16;
    localparam int TC      = CLK_HZ / STEP_HZ - 1;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_H     = 7'b0001001;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_1     = 7'b1111001;
    localparam logic [6:0] G_2     = 7'b0100100;
    localparam logic [6:0] G_DASH  = 7'b0111111;

    logic       clk, rst;
    logic       wr_en, start, pause;
    logic [3:0] wr_addr;
    logic [4:0] wr_data, msg_len;
    logic       busy, step;
    logic [6:0] hex3, hex2, hex1, hex0;

    int n_checks = 0;
    int n_pass   = 0;

    seg_scroll_engine #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .msg_len  (msg_len),
        .start    (start),
        .pause    (pause),
        .busy     (busy),
        .step     (step),
        .HEX3     (hex3),
        .HEX2     (hex2),
        .HEX1     (hex1),
        .HEX0     (hex0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [6:0] glyph(input int code);
        case (code)
            'h00: return 7'b1000000;
            'h01: return 7'b1111001;
            'h02: return 7'b0100100;
            'h03: return 7'b0110000;
            'h04: return 7'b0011001;
            'h05: return 7'b0010010;
            'h06: return 7'b0000010;
            'h07: return 7'b1111000;
            'h08: return 7'b0000000;
            'h09: return 7'b0010000;
            'h0A: return 7'b0001000;
            'h0B: return 7'b0000011;
            'h0C: return 7'b1000110;
            'h0D: return 7'b0100001;
            'h0E: return 7'b0000110;
            'h0F: return 7'b0001110;
            'h11: return 7'b0001001;
            'h12: return 7'b1000111;
            'h13: return 7'b0001100;
            'h14: return 7'b1000001;
            'h15: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: mode 0 idle, 1 running, 2 paused; window = buffer positions ptr..ptr+3 mod len.
    int         m_mode, m_ptr, m_len, m_cnt;
    bit         m_step;
    int         m_buf [MAX_LEN];
    logic [6:0] m_hex [4];
    logic [6:0] nh    [4];
    int         n_mode, n_ptr, n_len, n_cnt;
    bit         n_step, go;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_ptr = 0; m_len = 0; m_cnt = 0; m_step = 0;
            for (int i = 0; i < MAX_LEN; i++) m_buf[i] = 'h10;
            for (int k = 0; k < 4; k++) m_hex[k] = G_BLANK;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_mode == 0) nh[k] = G_BLANK;
                else nh[k] = glyph(m_buf[(m_ptr + k) % m_len]);
            end
            go = start && (msg_len != 0);
            n_mode = m_mode; n_ptr = m_ptr; n_len = m_len; n_cnt = m_cnt; n_step = 0;
            if (go) begin
                n_ptr = 0;
                n_cnt = 0;
                n_len = (int'(msg_len) > MAX_LEN) ? MAX_LEN : int'(msg_len);
            end else if (m_mode == 1) begin
                if (m_cnt == TC) begin
                    n_cnt  = 0;
                    n_step = 1;
                    n_ptr  = (m_ptr + 1) % m_len;
                end else begin
                    n_cnt = m_cnt + 1;
                end
            end
            if (m_mode == 0) begin
                if (go) n_mode = 1;
            end else begin
                n_mode = pause ? 2 : 1;
            end
            if (wr_en) m_buf[wr_addr] = int'(wr_data);
            m_mode = n_mode; m_ptr = n_ptr; m_len = n_len; m_cnt = n_cnt; m_step = n_step;
            for (int k = 0; k < 4; k++) m_hex[k] = nh[k];
        end
    end

    always @(negedge clk) begin
        check("m_busy", busy, (m_mode != 0));
        check("m_step", step, m_step);
        check("m_hex3", hex3, m_hex[0]);
        check("m_hex2", hex2, m_hex[1]);
        check("m_hex1", hex1, m_hex[2]);
        check("m_hex0", hex0, m_hex[3]);
    end

    task automatic put(input logic [3:0] addr, input logic [4:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic put_hello();
        put(4'd0, 5'h11);
        put(4'd1, 5'h0E);
        put(4'd2, 5'h12);
        put(4'd3, 5'h12);
        put(4'd4, 5'h00);
    endtask

    task automatic pulse_start(input logic [4:0] len);
        msg_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_step();
        bit seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (step === 1'b1) seen = 1;
        end
        check("step_arrives", seen, 1);
    endtask

    task automatic check_window(input string name, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        check({name, "_hex3"}, hex3, e3);
        check({name, "_hex2"}, hex2, e2);
        check({name, "_hex1"}, hex1, e1);
        check({name, "_hex0"}, hex0, e0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n_steps;
        int gap;
        bit seen;
        rst = 1'b0; wr_en = 1'b0; start = 1'b0; pause = 1'b0;
        wr_addr = '0; wr_data = '0; msg_len = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset with no stimulus.
        repeat (20) @(negedge clk);
        check_window("idle", G_BLANK, G_BLANK, G_BLANK, G_BLANK);
        check("idle_busy", busy, 0);
        check("idle_step", step, 0);

        // Zero length start is ignored.
        pulse_start(5'd0);
        repeat (3) @(negedge clk);
        check("len0_busy", busy, 0);
        check("len0_hex3", hex3, G_BLANK);

        // HELLO, then scroll through all five positions.
        put_hello();
        pulse_start(5'd5);
        @(negedge clk);
        check_window("hell", G_H, G_E, G_L, G_L);
        wait_step();
        @(negedge clk);
        check_window("ello", G_E, G_L, G_L, G_O);
        repeat (4) wait_step();
        @(negedge clk);
        check_window("hell_wrap", G_H, G_E, G_L, G_L);

        // Pause right after a step: count freezes at 1.
        wait_step();
        pause = 1'b1;
        n_steps = 0;
        repeat (20) begin
            @(negedge clk);
            if (step === 1'b1) n_steps++;
        end
        check("pause_no_step", n_steps, 0);
        pause = 1'b0;
        gap = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            gap++;
            if (step === 1'b1) seen = 1;
        end
        // One cycle to leave PAUSE, then counts 1..7 before the wrap.
        check("resume_gap", gap, 8);

        // Short message repeats across the digits.
        put(4'd0, 5'h01);
        put(4'd1, 5'h02);
        pulse_start(5'd2);
        @(negedge clk);
        check_window("len2", G_1, G_2, G_1, G_2);

        // Write buf[1] on the same edge as a step.
        put_hello();
        pulse_start(5'd5);
        repeat (7) @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 5'h15;
        @(negedge clk);
        wr_en = 1'b0;
        check("wstep_step", step, 1);
        check("wstep_old_hex3", hex3, G_H);
        check("wstep_old_hex2", hex2, G_E);
        @(negedge clk);
        check("wstep_new_hex3", hex3, G_DASH);
        check("wstep_new_hex2", hex2, G_L);

        // start and pause together, landing on what would have been a step edge.
        repeat (6) @(negedge clk);
        start = 1'b1; pause = 1'b1; msg_len = 5'd5;
        @(negedge clk);
        start = 1'b0;
        check("sp_no_step", step, 0);
        check("sp_busy", busy, 1);
        n_steps = 0;
        repeat (12) begin
            @(negedge clk);
            if (step === 1'b1) n_steps++;
        end
        check("sp_paused", n_steps, 0);
        check("sp_hex3", hex3, G_H);
        check("sp_hex2", hex2, G_DASH);
        pause = 1'b0;

        // Randomized traffic, including over-long lengths that clamp.
        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(3) == 0);
            wr_addr = 4'($urandom_range(15));
            wr_data = 5'($urandom_range(31));
            start   = ($urandom_range(149) == 0);
            msg_len = 5'($urandom_range(31));
            if ($urandom_range(39) == 0) pause = ~pause;
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b0; pause = 1'b0;

        // Asynchronous reset mid-scroll clears outputs and the buffer.
        put_hello();
        pulse_start(5'd5);
        @(negedge clk);
        check("pre_rst_hex3", hex3, G_H);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_hex3", hex3, G_BLANK);
        check("arst_hex0", hex0, G_BLANK);
        check("arst_busy", busy, 0);
        check("arst_step", step, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start(5'd5);
        @(negedge clk);
        check("post_rst_busy", busy, 1);
        check("post_rst_hex3", hex3, G_BLANK);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
